// File: rtl/fx_param_ctrl.sv
// FX parameter controller: debounced inc/dec/restore keys edit a bank of FX parameters.
// Optional hold acceleration is enabled by defining FX_PARAM_ACCEL_EN.

package lab_pkg;
    // Parameter 0 of each effect defaults to a small, effect-dependent value; the rest sit at mid-scale.
    function automatic int param_default(input int fx, input int p);
        return (p == 0) ? fx * 4 : 64;
    endfunction
endpackage

// Hold FSM for one key: one action on press, then auto-repeat while held.
//   state    | meaning
//   S_IDLE   | key released, or locked out by a simultaneous inc+dec hold
//   S_PRESS  | first action cycle after a stable rise
//   S_WAIT   | timer running toward the first repeat
//   S_REPEAT | one action each time the timer reaches terminal count
module fx_param_hold #(
    parameter int REPEAT_START_CNT = 15_000_000,
    parameter int REPEAT_RATE_CNT  = 2_000_000,
    parameter int ACCEL_AFTER      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stable,
    input  logic rise,
    input  logic cancel,
    output logic act,
    output logic coarse
);
    localparam int CNT_MAX = (REPEAT_START_CNT > REPEAT_RATE_CNT) ? REPEAT_START_CNT : REPEAT_RATE_CNT;
    localparam int TMR_W   = $clog2(CNT_MAX + 1);
    // WAIT runs START-2 down to 0, then REPEAT fires on entry: first repeat lands START cycles after PRESS.
    localparam logic [TMR_W-1:0] START_LD = TMR_W'(REPEAT_START_CNT - 2);
    localparam logic [TMR_W-1:0] RATE_LD  = TMR_W'(REPEAT_RATE_CNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_WAIT, S_REPEAT} hold_state_t;

    hold_state_t      state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        act       = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) state_nxt = S_PRESS;
            end
            S_PRESS: begin
                act       = 1'b1;
                state_nxt = S_WAIT;
                tmr_nxt   = START_LD;
            end
            S_WAIT: begin
                if (tmr == '0) state_nxt = S_REPEAT;
                else           tmr_nxt   = tmr - 1'b1;
            end
            S_REPEAT: begin
                if (tmr == '0) begin
                    act     = 1'b1;
                    tmr_nxt = RATE_LD;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!stable || cancel) begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
        end
        if (cancel) act = 1'b0;
    end

`ifdef FX_PARAM_ACCEL_EN
    localparam int RC_W = $clog2(ACCEL_AFTER + 2);
    localparam logic [RC_W-1:0] RC_SAT = RC_W'(ACCEL_AFTER);

    logic [RC_W-1:0] rep_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rep_cnt <= '0;
        end else if (state_nxt == S_IDLE) begin
            rep_cnt <= '0;
        end else if (act && state == S_REPEAT && rep_cnt != RC_SAT) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign coarse = (state == S_REPEAT) && (rep_cnt == RC_SAT);
`else
    assign coarse = 1'b0;
`endif
endmodule

module fx_param_ctrl #(
    parameter int FX_COUNT         = 16,
    parameter int PARAM_COUNT      = 8,
    parameter int PARAM_W          = 7,
    parameter int PARAM_MIN        = 0,
    parameter int PARAM_MAX        = 2**PARAM_W - 1,
    parameter int WRAP             = 0,
    parameter int STEP             = 1,
    parameter int STEP_COARSE      = 8,
    parameter int ACCEL_AFTER      = 8,
    parameter int DEBOUNCE_CNT_MAX = 1_000_000,
    parameter int REPEAT_START_CNT = 15_000_000,
    parameter int REPEAT_RATE_CNT  = 2_000_000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [$clog2(FX_COUNT)-1:0]    sw_fx_sel,
    input  logic [$clog2(PARAM_COUNT)-1:0] sw_param_sel,
    input  logic                           key_inc,
    input  logic                           key_dec,
    input  logic                           key_rst,
    output logic [PARAM_W-1:0]             params [0:FX_COUNT-1][0:PARAM_COUNT-1],
    output logic [$clog2(FX_COUNT)-1:0]    fx_sel,
    output logic [$clog2(PARAM_COUNT)-1:0] param_sel,
    output logic [PARAM_W-1:0]             current_value,
    output logic                           upd_valid,
    output logic [$clog2(FX_COUNT)-1:0]    upd_fx,
    output logic [$clog2(PARAM_COUNT)-1:0] upd_param,
    output logic [PARAM_W-1:0]             upd_value
);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT_MAX + 1);
    localparam logic [DEB_W-1:0] DEB_TC = DEB_W'(DEBOUNCE_CNT_MAX - 1);

    localparam logic [PARAM_W:0]   MAX_X    = (PARAM_W + 1)'(PARAM_MAX);
    localparam logic [PARAM_W:0]   MIN_X    = (PARAM_W + 1)'(PARAM_MIN);
    localparam logic [PARAM_W:0]   STEP_X   = (PARAM_W + 1)'(STEP);
    localparam logic [PARAM_W:0]   COARSE_X = (PARAM_W + 1)'(STEP_COARSE);
    localparam logic [PARAM_W-1:0] MAX_V    = PARAM_W'(PARAM_MAX);
    localparam logic [PARAM_W-1:0] MIN_V    = PARAM_W'(PARAM_MIN);

    function automatic logic [PARAM_W-1:0] def_clamp(input int fx, input int p);
        int d;
        d = lab_pkg::param_default(fx, p);
        if (d < PARAM_MIN) d = PARAM_MIN;
        if (d > PARAM_MAX) d = PARAM_MAX;
        return PARAM_W'(d);
    endfunction

    // Key lanes: bit 0 = inc, bit 1 = dec, bit 2 = restore default.
    logic [2:0]       keys, sync_a, sync_b, stable, stable_d, rise;
    logic [DEB_W-1:0] deb_cnt [3];
    logic             lock, cancel, rst_act;
    logic             inc_act, dec_act, inc_coarse, dec_coarse;

    assign keys = {key_rst, key_dec, key_inc};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_a   <= '0;
            sync_b   <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
        end else begin
            sync_a   <= keys;
            sync_b   <= sync_a;
            stable_d <= stable;
            for (int k = 0; k < 3; k++) begin
                if (sync_b[k] == stable[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_TC) begin
                    stable[k]  <= sync_b[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign rise = stable & ~stable_d;

    // Once inc and dec are both held, neither may act again until both are released.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock    <= 1'b0;
            rst_act <= 1'b0;
        end else begin
            if (stable[0] && stable[1])        lock <= 1'b1;
            else if (!stable[0] && !stable[1]) lock <= 1'b0;
            rst_act <= rise[2];
        end
    end

    assign cancel = (stable[0] && stable[1]) || lock;

    fx_param_hold #(
        .REPEAT_START_CNT (REPEAT_START_CNT),
        .REPEAT_RATE_CNT  (REPEAT_RATE_CNT),
        .ACCEL_AFTER      (ACCEL_AFTER)
    ) u_hold_inc (
        .clk     (clk),
        .reset_n (reset_n),
        .stable  (stable[0]),
        .rise    (rise[0]),
        .cancel  (cancel),
        .act     (inc_act),
        .coarse  (inc_coarse)
    );

    fx_param_hold #(
        .REPEAT_START_CNT (REPEAT_START_CNT),
        .REPEAT_RATE_CNT  (REPEAT_RATE_CNT),
        .ACCEL_AFTER      (ACCEL_AFTER)
    ) u_hold_dec (
        .clk     (clk),
        .reset_n (reset_n),
        .stable  (stable[1]),
        .rise    (rise[1]),
        .cancel  (cancel),
        .act     (dec_act),
        .coarse  (dec_coarse)
    );

    logic [PARAM_W-1:0] old_val, inc_val, dec_val, new_val;
    logic [PARAM_W:0]   old_x, inc_step, dec_step, inc_sum, dec_diff;
    logic               do_write;

    always_comb begin
        old_val  = params[sw_fx_sel][sw_param_sel];
        old_x    = {1'b0, old_val};
        inc_step = inc_coarse ? COARSE_X : STEP_X;
        dec_step = dec_coarse ? COARSE_X : STEP_X;
        inc_sum  = old_x + inc_step;
        dec_diff = old_x - dec_step;

        if (inc_sum > MAX_X) inc_val = (WRAP != 0) ? MIN_V : MAX_V;
        else                 inc_val = inc_sum[PARAM_W-1:0];

        if (old_x < MIN_X + dec_step) dec_val = (WRAP != 0) ? MAX_V : MIN_V;
        else                          dec_val = dec_diff[PARAM_W-1:0];

        new_val = old_val;
        if (rst_act)                  new_val = def_clamp(int'(sw_fx_sel), int'(sw_param_sel));
        else if (inc_act && !dec_act) new_val = inc_val;
        else if (dec_act && !inc_act) new_val = dec_val;

        do_write = (new_val != old_val);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int f = 0; f < FX_COUNT; f++)
                for (int p = 0; p < PARAM_COUNT; p++)
                    params[f][p] <= def_clamp(f, p);
            upd_valid <= 1'b0;
            upd_fx    <= '0;
            upd_param <= '0;
            upd_value <= '0;
        end else begin
            upd_valid <= 1'b0;
            if (do_write) begin
                params[sw_fx_sel][sw_param_sel] <= new_val;
                upd_valid <= 1'b1;
                upd_fx    <= sw_fx_sel;
                upd_param <= sw_param_sel;
                upd_value <= new_val;
            end
        end
    end

    assign fx_sel        = sw_fx_sel;
    assign param_sel     = sw_param_sel;
    assign current_value = params[sw_fx_sel][sw_param_sel];
endmodule

// File: tb/tb_fx_param_ctrl.sv
// Scoreboard bench for fx_param_ctrl: a saturating and a wrapping instance share one key stream.
module tb_fx_param_ctrl;
    localparam int NFX = 16;
    localparam int NP  = 8;
    localparam int W   = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [3:0]    sw_fx;
    logic [2:0]    sw_p;
    logic          k_inc, k_dec, k_rst;

    logic [W-1:0]  params0 [0:NFX-1][0:NP-1];
    logic [W-1:0]  params1 [0:NFX-1][0:NP-1];
    logic [3:0]    fxs0, fxs1, ufx0, ufx1;
    logic [2:0]    ps0, ps1, up0, up1;
    logic [W-1:0]  cur0, cur1, uval0, uval1;
    logic          uv0, uv1;

    fx_param_ctrl #(
        .FX_COUNT(NFX), .PARAM_COUNT(NP), .PARAM_W(W), .PARAM_MIN(0), .PARAM_MAX(127),
        .WRAP(0), .STEP(1), .STEP_COARSE(8), .ACCEL_AFTER(4),
        .DEBOUNCE_CNT_MAX(4), .REPEAT_START_CNT(20), .REPEAT_RATE_CNT(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sw_fx_sel(sw_fx), .sw_param_sel(sw_p),
        .key_inc(k_inc), .key_dec(k_dec), .key_rst(k_rst), .params(params0),
        .fx_sel(fxs0), .param_sel(ps0), .current_value(cur0), .upd_valid(uv0),
        .upd_fx(ufx0), .upd_param(up0), .upd_value(uval0)
    );

    fx_param_ctrl #(
        .FX_COUNT(NFX), .PARAM_COUNT(NP), .PARAM_W(W), .PARAM_MIN(0), .PARAM_MAX(127),
        .WRAP(1), .STEP(1), .STEP_COARSE(8), .ACCEL_AFTER(4),
        .DEBOUNCE_CNT_MAX(4), .REPEAT_START_CNT(20), .REPEAT_RATE_CNT(5)
    ) dut_w (
        .clk(clk), .reset_n(reset_n), .sw_fx_sel(sw_fx), .sw_param_sel(sw_p),
        .key_inc(k_inc), .key_dec(k_dec), .key_rst(k_rst), .params(params1),
        .fx_sel(fxs1), .param_sel(ps1), .current_value(cur1), .upd_valid(uv1),
        .upd_fx(ufx1), .upd_param(up1), .upd_value(uval1)
    );

    typedef struct {int fx; int p; int v;} upd_t;
    upd_t q0[$];
    upd_t q1[$];
    upd_t e0, e1;
    int   m [2][NFX][NP];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   press_cyc = 0;
    int   last_upd_cyc0 = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int dflt(input int fx, input int p);
        return (p == 0) ? fx * 4 : 64;
    endfunction

    // Monitor: every strobe must match the oldest pending expectation of its instance.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (uv0 === 1'b1) begin
                last_upd_cyc0 = cyc;
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_upd0: fx=%0d p=%0d value=%0d with nothing expected", ufx0, up0, uval0);
                end else begin
                    e0 = q0.pop_front();
                    check("upd0_fx", int'(ufx0), e0.fx);
                    check("upd0_param", int'(up0), e0.p);
                    check("upd0_value", int'(uval0), e0.v);
                end
            end
            if (uv1 === 1'b1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_upd1: fx=%0d p=%0d value=%0d with nothing expected", ufx1, up1, uval1);
                end else begin
                    e1 = q1.pop_front();
                    check("upd1_fx", int'(ufx1), e1.fx);
                    check("upd1_param", int'(up1), e1.p);
                    check("upd1_value", int'(uval1), e1.v);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int f = 0; f < NFX; f++)
                for (int p = 0; p < NP; p++)
                    m[i][f][p] = dflt(f, p);
    endtask

    // kind: 0 = inc, 1 = dec, 2 = restore default; instance 1 wraps, instance 0 saturates.
    task automatic model_apply(input int kind, input int stp);
        int fx, p, o, n;
        fx = int'(sw_fx);
        p  = int'(sw_p);
        for (int i = 0; i < 2; i++) begin
            o = m[i][fx][p];
            if (kind == 2)      n = dflt(fx, p);
            else if (kind == 0) n = (o + stp > 127) ? ((i == 1) ? 0 : 127) : o + stp;
            else                n = (o - stp < 0) ? ((i == 1) ? 127 : 0) : o - stp;
            if (n != o) begin
                m[i][fx][p] = n;
                if (i == 0) q0.push_back('{fx, p, n});
                else        q1.push_back('{fx, p, n});
            end
        end
    endtask

    function automatic int rep_step(input int r);
`ifdef FX_PARAM_ACCEL_EN
        return (r < 4) ? 1 : 8;
`else
        return (r == -1) ? 0 : 1;
`endif
    endfunction

    task automatic set_key(input int kind, input logic v);
        if (kind == 0)      k_inc = v;
        else if (kind == 1) k_dec = v;
        else                k_rst = v;
    endtask

    // Key high for 'hold' sampled edges; stable rises 6 edges in, PRESS acts after edge 7,
    // repeats after edges 27, 32, ... up to edge hold+6 when the stable level falls.
    task automatic press(input int kind, input int hold);
        int n_rep;
        n_rep = 0;
        if (kind != 2 && hold + 6 >= 27) n_rep = (hold + 6 - 27) / 5 + 1;
        model_apply(kind, 1);
        for (int r = 0; r < n_rep; r++) model_apply(kind, rep_step(r));
        @(negedge clk);
        press_cyc = cyc;
        set_key(kind, 1'b1);
        repeat (hold) @(negedge clk);
        set_key(kind, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic settle_check(input string name);
        check({name, "_pending0"}, q0.size(), 0);
        check({name, "_pending1"}, q1.size(), 0);
        check({name, "_cur0"}, int'(cur0), m[0][sw_fx][sw_p]);
        check({name, "_cur1"}, int'(cur1), m[1][sw_fx][sw_p]);
    endtask

    task automatic bank_check(input string name);
        int errs;
        errs = 0;
        for (int f = 0; f < NFX; f++)
            for (int p = 0; p < NP; p++) begin
                if (int'(params0[f][p]) != dflt(f, p)) errs++;
                if (int'(params1[f][p]) != dflt(f, p)) errs++;
            end
        check({name, "_bank_mismatches"}, errs, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        k_inc = 1'b0; k_dec = 1'b0; k_rst = 1'b0;
        sw_fx = 4'd0; sw_p = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        bank_check("reset");
        check("reset_upd_valid0", int'(uv0), 0);
        check("reset_upd_valid1", int'(uv1), 0);
        check("reset_upd_fx", int'(ufx0), 0);
        check("reset_upd_value", int'(uval0), 0);

        // Short glitch must never reach the stable level.
        sw_fx = 4'd2; sw_p = 3'd3;
        @(negedge clk);
        check("fx_sel_pass", int'(fxs0), 2);
        check("param_sel_pass", int'(ps0), 3);
        k_inc = 1'b1;
        repeat (3) @(negedge clk);
        k_inc = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_value", int'(cur0), 64);
        settle_check("glitch");

        press(0, 10);
        check("single_value", int'(cur0), 65);
        check("single_latency", last_upd_cyc0 - press_cyc, 8);
        settle_check("single");

        for (int i = 0; i < 25; i++) press(0, 10);
        check("to90_value", int'(cur0), 90);
        settle_check("to90");
        press(2, 10);
        check("restore_value", int'(cur0), 64);
        settle_check("restore");
        press(2, 10);
        settle_check("restore_again");

        sw_fx = 4'd5; sw_p = 3'd1;
        for (int i = 0; i < 62; i++) press(0, 10);
        check("to126_value", int'(cur0), 126);
        settle_check("to126");
        press(0, 10);
        check("sat_first0", int'(cur0), 127);
        check("sat_first1", int'(cur1), 127);
        settle_check("sat_first");
        press(0, 10);
        check("sat_hold0", int'(cur0), 127);
        check("wrap_over1", int'(cur1), 0);
        settle_check("sat_second");

        sw_fx = 4'd0; sw_p = 3'd0;
        press(1, 10);
        check("sat_min0", int'(cur0), 0);
        check("wrap_under1", int'(cur1), 127);
        settle_check("underflow");

        sw_fx = 4'd2; sw_p = 3'd0;
        press(0, 10);
        press(0, 10);
        check("accel_start", int'(cur0), 10);
        press(0, 63);
`ifdef FX_PARAM_ACCEL_EN
        check("accel_end", int'(cur0), 55);
`else
        check("accel_end", int'(cur0), 20);
`endif
        settle_check("accel");

        // Both keys together: held long enough that a single key would have repeated.
        sw_fx = 4'd2; sw_p = 3'd3;
        @(negedge clk);
        k_inc = 1'b1; k_dec = 1'b1;
        repeat (40) @(negedge clk);
        k_inc = 1'b0; k_dec = 1'b0;
        repeat (12) @(negedge clk);
        check("simul_value", int'(cur0), 64);
        settle_check("simul");

        // Reset while repeating: press + 3 repeats land before the reset edge.
        sw_fx = 4'd3; sw_p = 3'd2;
        for (int i = 0; i < 4; i++) model_apply(0, 1);
        @(negedge clk);
        k_inc = 1'b1;
        repeat (40) @(negedge clk);
        check("midrep_value", int'(cur0), 68);
        settle_check("midrep");
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        bank_check("midrep_reset");
        check("midrep_upd_valid", int'(uv0), 0);
        repeat (2) @(negedge clk);
        k_inc = 1'b0;
        repeat (20) @(negedge clk);
        check("held_after_reset", int'(cur0), 64);
        settle_check("held_after_reset");
        press(0, 10);
        check("repress_value", int'(cur0), 65);
        settle_check("repress");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fx_param_ctrl.md
# fx_param_ctrl

Next-generation FX parameter controller. Turns debounced increment, decrement and restore-default keys into saturating or wrapping edits of a parameter bank of FX_COUNT × PARAM_COUNT values. Adds configurable step sizes, optional hold acceleration, simultaneous-key cancel, and a one-cycle update strobe for downstream FX cores. Sits between the board switches and keys and the FX pipeline / display driver.

## Interface
- FX_COUNT, 16, number of effects
- PARAM_COUNT, 8, parameters per effect
- PARAM_W, 7, parameter width (bits)
- PARAM_MIN, 0, lower bound (inclusive)
- PARAM_MAX, 2**PARAM_W-1, upper bound (inclusive); PARAM_MIN < PARAM_MAX
- WRAP, 0, 0 = saturate at bounds, 1 = wrap to opposite bound
- STEP, 1, fine step applied per press or repeat
- STEP_COARSE, 8, accelerated step (used only with FX_PARAM_ACCEL_EN)
- ACCEL_AFTER, 8, repeat count before coarse step applies
- DEBOUNCE_CNT_MAX, 1_000_000, debounce stability window (cycles)
- REPEAT_START_CNT, 15_000_000, hold time before first repeat (cycles)
- REPEAT_RATE_CNT, 2_000_000, repeat period (cycles)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- sw_fx_sel  in  $clog2(FX_COUNT)  effect select
- sw_param_sel  in  $clog2(PARAM_COUNT)  parameter select
- key_inc / key_dec / key_rst  in  1 each  raw active-high keys, asynchronous
- params  out  PARAM_W, [0:FX_COUNT-1][0:PARAM_COUNT-1]  parameter bank
- fx_sel, param_sel  out  as inputs  current selection, combinational pass-through
- current_value  out  PARAM_W  params[fx_sel][param_sel], combinational
- upd_valid  out  1  one-cycle strobe: a parameter changed this cycle
- upd_fx, upd_param  out  as selects  address of the changed parameter
- upd_value  out  PARAM_W  new value

## Operation
- Reset: params[fx][p] = lab_pkg::param_default(fx,p). All synchronizers, counters, FSMs and upd_* are 0.
- Per key: 2-FF synchronizer, then a debounce counter. The stable level toggles only after the synchronized level differs from it for DEBOUNCE_CNT_MAX consecutive cycles. Any equal sample clears the counter.
- inc and dec each have a hold FSM: IDLE → PRESS (on stable rise; emits one action) → WAIT (counts to REPEAT_START_CNT) → REPEAT (emits one action every REPEAT_RATE_CNT cycles). Any state returns to IDLE on stable fall.
- key_rst emits one action on stable rise only; it has no repeat.
- Action priority per cycle: rst > (inc XOR dec). If inc and dec act in the same cycle, both are dropped. If both stable levels are high, both FSMs are forced to IDLE until both are released.
- Arithmetic is done in PARAM_W+1 bits.
  - Saturate: inc gives min(v+s, PARAM_MAX); dec gives max(v−s, PARAM_MIN).
  - Wrap: overflow past PARAM_MAX gives PARAM_MIN; underflow past PARAM_MIN gives PARAM_MAX. There is no modular remainder.
- rst action writes param_default(fx_sel, param_sel).
- Only the selected entry is written. Selection is sampled in the action cycle.
- upd_valid asserts only if the new value differs from the old value. No strobe when saturated or when restoring an unchanged default.
- Reset asserted mid-hold or mid-debounce: everything returns to reset state. A key still held after reset must debounce and rise again before it acts.

## Timing
- Synchronizer: 2 cycles. Debounce: DEBOUNCE_CNT_MAX cycles.
- Action pulse is registered 1 cycle after the stable rise.
- params and upd_* are updated at the next edge, in the same cycle as each other.
- First repeat: REPEAT_START_CNT cycles after the PRESS action. Subsequent repeats: every REPEAT_RATE_CNT cycles.
- current_value reflects the write 1 cycle after the action, with zero additional latency.
- upd_valid is high for exactly 1 cycle per changed write. Back-to-back strobes are legal.

## Configuration
- FX_PARAM_ACCEL_EN defined:
  - The REPEAT state counts emitted repeats, saturating at ACCEL_AFTER.
  - The first ACCEL_AFTER repeats use STEP; later repeats use STEP_COARSE.
  - The count clears on release.
  - PRESS actions always use STEP.
- Undefined: all actions use STEP. The repeat counter and STEP_COARSE logic are absent.

## Test plan
Bench parameters: DEBOUNCE=4, START=20, RATE=5, STEP=1, COARSE=8, ACCEL_AFTER=4, WRAP=0.
- Reset check: after reset, every params entry equals param_default; upd_valid=0. Then a 3-cycle key_inc glitch → no change, no strobe.
- Single press: hold key_inc for 10 cycles on fx=2, p=3 with default 64 → value 65, exactly one upd_valid with upd_fx=2, upd_param=3, upd_value=65.
- Saturate: value 126, press inc twice → 127 with one strobe, then 127 with no strobe. Repeat with WRAP=1 → 127 then 0, two strobes.
- Accel (macro on): hold inc from 10 for 60 cycles after PRESS → 11, 12, 13, 14, 15, then 23, 31…; with the macro off, every step is +1.
- Simultaneous and reset: inc and dec pressed together → no change. key_rst on value 90 with default 64 → 64 with a strobe. reset_n low during a repeat → defaults restored and the held key does not act until re-pressed.
